keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 194 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : Scans a 4x4 active-low matrix keypad, debounces the selected key
//            on both press and release, and emits exactly one single-cycle
//            event per physical key press (digit, start '#' or clear '*').
//            Intended to run on a 1 kHz clock (one cycle = 1 ms).
// Revision : 1.0 - initial release
//
// Ports
//   clk       in   1  clock (1 kHz after division)
//   rst_n     in   1  synchronous reset, active-HIGH despite the name
//   row       out  4  row drive, active-low, exactly one bit low
//   col       in   4  column sense, active-low, externally pulled up
//   pressed   out  1  one-cycle pulse: digit key accepted
//   key_value out  4  last accepted digit (0-9), valid with pressed
//   start     out  1  one-cycle pulse: '#' accepted
//   clear     out  1  one-cycle pulse: '*' accepted
//   key_held  out  1  high from the fire cycle until release debounce ends
// ============================================================================
module keypad_scanner #(
   parameter int DEBOUNCE_CYC = 20,   // stable cycles for press and release (2..255)
   parameter int SCAN_DWELL   = 2     // cycles a row is driven before sampling (1..15)
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic       pressed,
   output logic [3:0] key_value,
   output logic       start,
   output logic       clear,
   output logic       key_held
);

   localparam logic [3:0] DWELL_LAST = 4'(SCAN_DWELL - 1);
   localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      FIRE     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] ridx, ridx_nxt;
   logic [1:0] cidx, cidx_nxt;
   logic [3:0] dwell, dwell_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       fire_go;
   logic       release_done;

   logic [1:0] low_cidx;
   logic       is_digit;
   logic       is_start;
   logic       is_clear;
   logic [3:0] digit_val;

   assign row = ~(4'b0001 << ridx);

   // Lowest-index low column wins when several keys share the row.
   always_comb begin
      low_cidx = 2'd0;
      if      (!col[0]) low_cidx = 2'd0;
      else if (!col[1]) low_cidx = 2'd1;
      else if (!col[2]) low_cidx = 2'd2;
      else if (!col[3]) low_cidx = 2'd3;
   end

   // Key classification uses only the latched row/column, so the pulse
   // outputs never depend combinationally on col.
   always_comb begin
      is_digit  = 1'b0;
      is_start  = 1'b0;
      is_clear  = 1'b0;
      digit_val = 4'd0;
      if (ridx != 2'd3) begin
         if (cidx != 2'd3) begin
            is_digit  = 1'b1;
            digit_val = ({2'b00, ridx} * 4'd3) + {2'b00, cidx} + 4'd1;
         end
      end else begin
         case (cidx)
            2'd0:    is_clear = 1'b1;
            2'd1:    is_digit = 1'b1;   // '0'
            2'd2:    is_start = 1'b1;
            default: ;                  // 'D': no event
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state <= SCAN;
         ridx  <= 2'd0;
         cidx  <= 2'd0;
         dwell <= 4'd0;
         cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         ridx  <= ridx_nxt;
         cidx  <= cidx_nxt;
         dwell <= dwell_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ridx_nxt     = ridx;
      cidx_nxt     = cidx;
      dwell_nxt    = dwell;
      cnt_nxt      = cnt;
      fire_go      = 1'b0;
      release_done = 1'b0;
      case (state)
         SCAN: begin
            if (dwell == DWELL_LAST) begin
               dwell_nxt = 4'd0;
               if (col != 4'hF) begin
                  cidx_nxt  = low_cidx;
                  cnt_nxt   = 8'd0;
                  state_nxt = DEBOUNCE;
               end else begin
                  ridx_nxt = ridx + 2'd1;
               end
            end else begin
               dwell_nxt = dwell + 4'd1;
            end
         end
         DEBOUNCE: begin
            if (!col[cidx]) begin
               if (cnt == DEB_LAST) begin
                  state_nxt = FIRE;
                  fire_go   = 1'b1;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end else begin
               // Bounce: rescan the same row from the start of its dwell.
               state_nxt = SCAN;
               dwell_nxt = 4'd0;
            end
         end
         FIRE: begin
            state_nxt = RELEASE;
            cnt_nxt   = 8'd0;
         end
         RELEASE: begin
            if (col == 4'hF) begin
               if (cnt == DEB_LAST) begin
                  release_done = 1'b1;
                  state_nxt    = SCAN;
                  ridx_nxt     = ridx + 2'd1;
                  dwell_nxt    = 4'd0;
                  cnt_nxt      = 8'd0;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end else begin
               cnt_nxt = 8'd0;
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   // Event outputs are registered on the edge entering FIRE, so they are
   // high exactly during the FIRE cycle.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         pressed   <= 1'b0;
         start     <= 1'b0;
         clear     <= 1'b0;
         key_value <= 4'd0;
         key_held  <= 1'b0;
      end else begin
         pressed <= fire_go & is_digit;
         start   <= fire_go & is_start;
         clear   <= fire_go & is_clear;
         if (fire_go && is_digit) begin
            key_value <= digit_val;
         end
         if (fire_go) begin
            key_held <= 1'b1;
         end else if (release_done) begin
            key_held <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed self-checking bench for keypad_scanner with a behavioural
//            4x4 key matrix (pressed key shorts its row to its column).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        pressed;
   logic [3:0]  key_value;
   logic        start;
   logic        clear;
   logic        key_held;

   logic [15:0] keys;          // bit r*4+c set = key at row r, col c held

   int checks;
   int failures;
   int n_pressed;
   int n_start;
   int n_clear;
   int n_multi;

   keypad_scanner #(
      .DEBOUNCE_CYC (20),
      .SCAN_DWELL   (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row       (row),
      .col       (col),
      .pressed   (pressed),
      .key_value (key_value),
      .start     (start),
      .clear     (clear),
      .key_held  (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key matrix: a held key pulls its column low while its row is driven low.
   always_comb begin
      col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
         end
      end
   end

   // Event counters, sampled on the falling edge.
   initial begin
      n_pressed = 0;
      n_start   = 0;
      n_clear   = 0;
      n_multi   = 0;
   end
   always @(negedge clk) begin
      if (pressed) n_pressed++;
      if (start)   n_start++;
      if (clear)   n_clear++;
      if ((int'(pressed) + int'(start) + int'(clear)) > 1) n_multi++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Hold a key for hold_cyc cycles, then release and let release debounce finish.
   task automatic tap(input int idx, input int hold_cyc);
      keys[idx] = 1'b1;
      ticks(hold_cyc);
      keys[idx] = 1'b0;
      ticks(25);
   endtask

   // Return at the first cycle in which target is newly driven (dwell 0).
   task automatic wait_row_fresh(input logic [3:0] target, input string tag);
      int n;
      n = 0;
      while (row == target && n < 40) begin tick(); n++; end
      while (row != target && n < 40) begin tick(); n++; end
      if (n >= 40) check({tag, "_timeout"}, 32'(row), 32'(target));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      keys     = 16'h0;
      rst_n    = 1'b1;
      ticks(3);
      check("rst_row",       32'(row),       32'hE);
      check("rst_pressed",   32'(pressed),   32'h0);
      check("rst_start",     32'(start),     32'h0);
      check("rst_clear",     32'(clear),     32'h0);
      check("rst_key_held",  32'(key_held),  32'h0);
      check("rst_key_value", 32'(key_value), 32'h0);
      rst_n = 1'b0;
      ticks(2);

      // '5' held 60 cycles; key_held must persist 20 cycles past release.
      keys[5] = 1'b1;
      ticks(60);
      check("k5_held_during", 32'(key_held), 32'h1);
      keys[5] = 1'b0;
      ticks(19);
      check("k5_held_19", 32'(key_held), 32'h1);
      tick();
      check("k5_held_20",  32'(key_held), 32'h0);
      check("k5_row_next", 32'(row),      32'hB);
      ticks(5);
      check("k5_count", 32'(n_pressed), 32'd1);
      check("k5_value", 32'(key_value), 32'd5);
      check("k5_start", 32'(n_start),   32'd0);
      check("k5_clear", 32'(n_clear),   32'd0);

      // '#' then '0'.
      tap(14, 60);
      check("hash_start",   32'(n_start),   32'd1);
      check("hash_pressed", 32'(n_pressed), 32'd1);
      check("hash_value",   32'(key_value), 32'd5);
      tap(13, 60);
      check("k0_count", 32'(n_pressed), 32'd2);
      check("k0_value", 32'(key_value), 32'd0);

      // Bounce on '7': low 5, high 2, then low 40. Final run is first
      // sampled in the cycle starting at point 7; pulse expected 21 later.
      wait_row_fresh(4'hB, "k7_sync");
      keys[8] = 1'b1;
      ticks(5);
      keys[8] = 1'b0;
      ticks(2);
      keys[8] = 1'b1;
      ticks(20);
      check("k7_no_early", 32'(pressed),   32'h0);
      check("k7_no_bounce",32'(n_pressed), 32'd2);
      tick();
      check("k7_pulse",    32'(pressed),   32'h1);
      check("k7_value",    32'(key_value), 32'd7);
      ticks(19);
      keys[8] = 1'b0;
      ticks(25);
      check("k7_count", 32'(n_pressed), 32'd3);

      // '1' held, '9' added, '1' released, '9' released before rescan.
      keys[0] = 1'b1;
      ticks(30);
      keys[10] = 1'b1;
      ticks(10);
      keys[0] = 1'b0;
      ticks(10);
      keys[10] = 1'b0;
      ticks(30);
      check("multi_count", 32'(n_pressed), 32'd4);
      check("multi_value", 32'(key_value), 32'd1);
      check("multi_held",  32'(key_held),  32'h0);

      // 'A': debounced, no event, key_held still tracks it.
      keys[3] = 1'b1;
      ticks(40);
      check("kA_held",    32'(key_held),  32'h1);
      check("kA_pressed", 32'(n_pressed), 32'd4);
      check("kA_start",   32'(n_start),   32'd1);
      keys[3] = 1'b0;
      ticks(25);
      check("kA_released", 32'(key_held), 32'h0);
      tap(2, 40);
      check("k3_count", 32'(n_pressed), 32'd5);
      check("k3_value", 32'(key_value), 32'd3);

      // '*'.
      tap(12, 40);
      check("star_clear",   32'(n_clear),   32'd1);
      check("star_pressed", 32'(n_pressed), 32'd5);

      // Reset mid-debounce on '8'.
      wait_row_fresh(4'hB, "k8_sync");
      keys[9] = 1'b1;
      ticks(12);
      rst_n   = 1'b1;
      keys[9] = 1'b0;
      tick();
      rst_n   = 1'b0;
      check("k8rst_row",       32'(row),       32'hE);
      check("k8rst_key_value", 32'(key_value), 32'h0);
      check("k8rst_key_held",  32'(key_held),  32'h0);
      check("k8rst_pressed",   32'(pressed),   32'h0);
      ticks(2);
      check("k8rst_scan", 32'(row), 32'hD);
      ticks(30);
      check("k8rst_no_pulse", 32'(n_pressed), 32'd5);
      check("one_hot_events", 32'(n_multi),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
